inst_encoder: RTL
=================

Name: inst_encoder

Overview:
- Packs decoded instruction fields and a 32-bit immediate into a 32-bit RV32I instruction word. It is the inverse of the core's immediate generator.
- It is used by the boot/program loader path to build instruction-memory images from field-level requests.
- It range- and alignment-checks each immediate and rejects illegal requests with an error pulse.
- Accepted words are emitted through a registered valid/ready output together with a sequential write address.

Parameters:
- ADDR_W, 8, width of the instruction-memory word address counter.
- START_ADDR, 0, address value loaded on reset and on clr_addr.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  encoder can accept a request this cycle
- in_fmt  input  3  format: 0=I, 1=S, 2=B, 3=U, 4=J; 5-7 illegal
- in_opcode  input  7  opcode field, placed at inst[6:0]
- in_rd  input  5  rd, placed at inst[11:7] (I/U/J formats)
- in_rs1  input  5  rs1, placed at inst[19:15] (I/S/B formats)
- in_rs2  input  5  rs2, placed at inst[24:20] (S/B formats)
- in_funct3  input  3  funct3, placed at inst[14:12] (I/S/B formats)
- in_imm  input  32  immediate as the core's immediate generator would output it
- clr_addr  input  1  synchronous reload of the address counter to START_ADDR
- out_valid  output  1  out_inst/out_addr valid
- out_ready  input  1  downstream accepts the output
- out_inst  output  32  encoded instruction
- out_addr  output  ADDR_W  word address for out_inst
- err_valid  output  1  one-cycle pulse: a request was rejected
- err_code  output  2  01=range, 10=misaligned, 11=illegal fmt/opcode; held until the next error
- wrapped  output  1  sticky: the address counter has wrapped

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_inst=0, out_addr=START_ADDR, err_valid=0, err_code=00, wrapped=0, FSM=EMPTY.
- FSM states:
  - EMPTY: the output register holds nothing.
  - FULL: the output register holds a word.
- in_ready = (state==EMPTY) | out_ready. It is combinational and does not depend on in_valid.
- A request is accepted when in_valid & in_ready. The check and pack are combinational; the result is registered.
- Latency: accept in cycle N gives out_valid=1 in cycle N+1.
- Legality checks, in priority order:
  - Illegal fmt (5-7) or in_opcode[1:0]!=2'b11 gives err 11.
  - Misaligned (B or J with in_imm[0]=1) gives err 10.
  - Range gives err 01:
    - I/S: in_imm[31:11] not all equal.
    - B: in_imm[31:12] not all equal.
    - J: in_imm[31:20] not all equal.
    - U: in_imm[11:0]!=0.
- Rejected request: it is consumed (handshake completes), nothing is emitted, and the address does not advance. err_valid pulses high in cycle N+1 with err_code.
- Packing:
  - I: {imm[11:0],rs1,f3,rd,op}
  - S: {imm[11:5],rs2,rs1,f3,imm[4:0],op}
  - B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}
  - U: {imm[31:12],rd,op}
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
- Transitions:
  - EMPTY: a legal accept goes to FULL.
  - FULL: out_ready without a legal accept goes to EMPTY.
  - FULL: out_ready with a legal accept in the same cycle stays FULL, loads the new word, and gives full throughput.
  - FULL: no out_ready keeps out_inst and out_addr stable, with in_ready=0.
  - A rejected request in the same cycle as out_ready goes to EMPTY.
- Address:
  - out_addr increments on each output handshake (out_valid & out_ready).
  - At 2^ADDR_W-1 it wraps to 0 and sets wrapped (cleared only by reset).
  - The word loaded after a handshake carries the incremented address.
  - clr_addr has priority over increment. It does not clear wrapped and does not disturb out_valid, but the held word's out_addr becomes START_ADDR.
- Reset mid-transfer drops any held word immediately; no partial output.

Optional Feature:
- INST_ENCODER_SELFCHECK_EN
- Defined:
  - The packed word is re-decoded internally into a 32-bit immediate using the core's immediate-generator rules, selected by in_fmt.
  - It is compared to in_imm.
  - On mismatch, the word is still emitted and a sticky output selfchk_fail (1 bit, reset 0) is set.
- Undefined: the selfchk_fail port is absent and there is no compare logic.

Test Plan:
- I fmt, op=0010011, rd=1, rs1=0, f3=0, imm=0xFFFFFFFF -> out_inst=0xFFF00093, out_addr=0, out_valid one cycle after accept.
- S op=0100011, f3=010, rs1=1, rs2=2, imm=8, then U op=0110111, rd=5, imm=0x12345000, then J op=1101111, rd=1, imm=8, back-to-back with out_ready=1:
  - Words 0x0020A423, 0x123452B7, 0x008000EF.
  - Addresses 0, 1, 2.
  - in_ready stays high throughout.
- B op=1100011, rs1=rs2=0, f3=0, imm=0xFFFFFFFC -> 0xFE000EE3. With out_ready=0 for 3 cycles: out_inst stable, in_ready=0, address unchanged until release.
- Illegal requests, each consumed with address unchanged and no out_valid:
  - I imm=0x800 -> err_valid pulse, err_code=01.
  - B imm=5 -> err_code=10.
  - fmt=6 -> err_code=11.
- ADDR_W=2: 5 legal words -> addresses 0, 1, 2, 3, 0 and wrapped=1 after the 4th handshake. clr_addr -> next address START_ADDR with wrapped still 1. Async reset mid-stall -> all outputs at reset values.

Source files
------------

// File: rtl/inst_encoder.sv
// ----------------------------------------------------------------------------
// inst_encoder
// Packs decoded RV32I instruction fields plus a 32-bit immediate into a
// 32-bit instruction word (the inverse of the core's immediate generator).
// Each immediate is range/alignment checked; illegal requests are consumed
// and reported through a one-cycle err_valid pulse with a held err_code.
// Legal words leave through a one-deep registered valid/ready output
// together with a sequential word address.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake (in_ready is combinational)
//   in_fmt              0=I 1=S 2=B 3=U 4=J, 5-7 illegal
//   in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm   request fields
//   clr_addr            synchronous reload of the address counter
//   out_valid/out_ready output handshake
//   out_inst, out_addr  encoded word and its word address
//   err_valid, err_code reject pulse, code 01 range/10 misaligned/11 illegal
//   wrapped             sticky, address counter has wrapped
//   selfchk_fail        sticky re-decode mismatch (optional, see below)
//
// Optional feature macro: INST_ENCODER_SELFCHECK_EN
//   When defined, every packed word is re-decoded into an immediate and
//   compared with in_imm; a mismatch sets the sticky selfchk_fail output.
// ----------------------------------------------------------------------------
module inst_encoder #(
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [31:0]       in_imm,
    input  logic              clr_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_valid,
    output logic [1:0]        err_code,
`ifdef INST_ENCODER_SELFCHECK_EN
    output logic              selfchk_fail,
`endif
    output logic              wrapped
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [2:0] FMT_I = 3'd0;
    localparam logic [2:0] FMT_S = 3'd1;
    localparam logic [2:0] FMT_B = 3'd2;
    localparam logic [2:0] FMT_U = 3'd3;
    localparam logic [2:0] FMT_J = 3'd4;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_RANGE   = 2'b01;
    localparam logic [1:0] ERR_ALIGN   = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    // Legality check in priority order: illegal fmt/opcode, misaligned, range.
    // "Range" means the bits above the encodable field are a pure sign
    // extension (or, for U, that the low 12 bits are zero).
    function automatic logic [1:0] check_req(input logic [2:0]  fmt,
                                             input logic [6:0]  op,
                                             input logic [31:0] imm);
        logic       range_bad;
        logic [1:0] code;
        case (fmt)
            FMT_I, FMT_S: range_bad = (imm[31:11] != {21{imm[11]}});
            FMT_B:        range_bad = (imm[31:12] != {20{imm[12]}});
            FMT_U:        range_bad = (imm[11:0]  != 12'h000);
            FMT_J:        range_bad = (imm[31:20] != {12{imm[20]}});
            default:      range_bad = 1'b0;
        endcase
        if ((fmt > FMT_J) || (op[1:0] != 2'b11)) begin
            code = ERR_ILLEGAL;
        end else if (((fmt == FMT_B) || (fmt == FMT_J)) && imm[0]) begin
            code = ERR_ALIGN;
        end else if (range_bad) begin
            code = ERR_RANGE;
        end else begin
            code = ERR_NONE;
        end
        return code;
    endfunction

    // Scatter the immediate into the RV32I format-specific bit positions.
    function automatic logic [31:0] pack_word(input logic [2:0]  fmt,
                                              input logic [6:0]  op,
                                              input logic [4:0]  rd,
                                              input logic [4:0]  rs1,
                                              input logic [4:0]  rs2,
                                              input logic [2:0]  f3,
                                              input logic [31:0] imm);
        logic [31:0] w;
        case (fmt)
            FMT_I:   w = {imm[11:0], rs1, f3, rd, op};
            FMT_S:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            FMT_U:   w = {imm[31:12], rd, op};
            FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

`ifdef INST_ENCODER_SELFCHECK_EN
    // Immediate-generator rules of the core, used to re-decode a packed word.
    function automatic logic [31:0] decode_imm(input logic [2:0]  fmt,
                                               input logic [31:0] i);
        logic [31:0] imm;
        case (fmt)
            FMT_I:   imm = {{20{i[31]}}, i[31:20]};
            FMT_S:   imm = {{20{i[31]}}, i[31:25], i[11:7]};
            FMT_B:   imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            FMT_U:   imm = {i[31:12], 12'h000};
            FMT_J:   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: imm = 32'h0000_0000;
        endcase
        return imm;
    endfunction
`endif

    state_t            state_r;
    logic              out_valid_r;
    logic [31:0]       out_inst_r;
    logic [ADDR_W-1:0] addr_r;
    logic              err_valid_r;
    logic [1:0]        err_code_r;
    logic              wrapped_r;

    logic              in_ready_s;
    logic              accept_s;
    logic [1:0]        req_err_s;
    logic              load_s;
    logic              reject_s;
    logic              out_hs_s;
    logic [31:0]       packed_s;

    // Room exists when the output register is empty or is being drained.
    assign in_ready_s = (state_r == EMPTY) | out_ready;
    assign accept_s   = in_valid & in_ready_s;
    assign req_err_s  = check_req(in_fmt, in_opcode, in_imm);
    assign packed_s   = pack_word(in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
                                  in_funct3, in_imm);
    assign load_s     = accept_s & (req_err_s == ERR_NONE);
    assign reject_s   = accept_s & (req_err_s != ERR_NONE);
    assign out_hs_s   = out_valid_r & out_ready;

    // Output-register FSM, held word and error reporting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= EMPTY;
            out_valid_r <= 1'b0;
            out_inst_r  <= 32'h0000_0000;
            err_valid_r <= 1'b0;
            err_code_r  <= ERR_NONE;
        end else begin
            err_valid_r <= reject_s;
            if (reject_s) begin
                err_code_r <= req_err_s;
            end
            if (load_s) begin
                out_inst_r <= packed_s;
            end
            case (state_r)
                EMPTY: begin
                    if (load_s) begin
                        state_r     <= FULL;
                        out_valid_r <= 1'b1;
                    end else begin
                        state_r     <= EMPTY;
                        out_valid_r <= 1'b0;
                    end
                end
                FULL: begin
                    if (load_s) begin
                        // drain and refill in the same cycle
                        state_r     <= FULL;
                        out_valid_r <= 1'b1;
                    end else if (out_ready) begin
                        state_r     <= EMPTY;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r     <= FULL;
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= EMPTY;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Word address counter: reload beats increment; wrap sets the sticky flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r    <= START_ADDR;
            wrapped_r <= 1'b0;
        end else begin
            if (clr_addr) begin
                addr_r <= START_ADDR;
            end else if (out_hs_s) begin
                addr_r <= addr_r + ADDR_ONE;
                if (addr_r == ADDR_MAX) begin
                    wrapped_r <= 1'b1;
                end
            end
        end
    end

`ifdef INST_ENCODER_SELFCHECK_EN
    logic selfchk_fail_r;

    // Sticky flag: a loaded word does not decode back to the requested imm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            selfchk_fail_r <= 1'b0;
        end else if (load_s && (decode_imm(in_fmt, packed_s) != in_imm)) begin
            selfchk_fail_r <= 1'b1;
        end
    end

    assign selfchk_fail = selfchk_fail_r;
`endif

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_inst  = out_inst_r;
    assign out_addr  = addr_r;
    assign err_valid = err_valid_r;
    assign err_code  = err_code_r;
    assign wrapped   = wrapped_r;

endmodule
